// File: rtl/writeback_pc_update.sv
// Y86-64 sequential write-back and PC-update stage.
// Holds the 15-entry register file, the PC and the architectural status.
// On a committed instruction it writes valE/valM back, selects the next PC,
// and freezes all state on the first non-AOK status until reset.
module writeback_pc_update #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] RSP_INIT = 64'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic        imem_error,
    input  logic        instr_valid,
    input  logic        dmem_error,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] pc,
    output logic [2:0]  stat,
    output logic        running
);

    typedef enum logic [2:0] {
        ST_AOK = 3'd1,
        ST_HLT = 3'd2,
        ST_ADR = 3'd3,
        ST_INS = 3'd4
    } stat_t;

    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } state_t;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    logic [63:0] regs [0:14];
    logic [63:0] pc_q;
    stat_t       stat_q;
    state_t      state;

    stat_t       instr_stat;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] new_pc;

    // Status of the instruction presented this cycle, in fault priority order
    always_comb begin
        instr_stat = ST_AOK;
        if (imem_error)
            instr_stat = ST_ADR;
        else if (!instr_valid)
            instr_stat = ST_INS;
        else if (dmem_error)
            instr_stat = ST_ADR;
        else if (icode == 4'h0)
            instr_stat = ST_HLT;
    end

    // Destination registers and next-PC selection from icode/cnd
    always_comb begin
        dst_e  = REG_NONE;
        dst_m  = REG_NONE;
        new_pc = valP;
        case (icode)
            4'h2:                      if (cnd) dst_e = rB;
            4'h3, 4'h6:                dst_e = rB;
            4'h8, 4'h9, 4'hA, 4'hB:    dst_e = REG_RSP;
            default:                   dst_e = REG_NONE;
        endcase
        case (icode)
            4'h5, 4'hB:                dst_m = rA;
            default:                   dst_m = REG_NONE;
        endcase
        case (icode)
            4'h7:                      if (cnd) new_pc = valC;
            4'h8:                      new_pc = valC;
            4'h9:                      new_pc = valM;
            default:                   new_pc = valP;
        endcase
    end

    // Architectural state: reset, commit of AOK instructions, freeze on fault
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 15; i++)
                regs[i] <= (i == 4) ? RSP_INIT : '0;
            pc_q   <= RESET_PC;
            stat_q <= ST_AOK;
            state  <= RUN;
        end else if (commit && state == RUN) begin
            if (instr_stat == ST_AOK) begin
                // popq %rsp: valM must win, so the E port yields on a clash
                if (dst_e != REG_NONE && dst_e != dst_m)
                    regs[dst_e] <= valE;
                if (dst_m != REG_NONE)
                    regs[dst_m] <= valM;
                pc_q <= new_pc;
            end else begin
                stat_q <= instr_stat;
                state  <= STOP;
            end
        end
    end

    // Read-before-write register file read ports
    always_comb begin
        valA = (srcA == REG_NONE) ? '0 : regs[srcA];
        valB = (srcB == REG_NONE) ? '0 : regs[srcB];
    end

    assign pc      = pc_q;
    assign stat    = stat_q;
    assign running = (state == RUN);

endmodule
